// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI packet receiver.
package spi_pkg;

  localparam int PKT_BITS_DEF = 24;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] arg;
  } pkt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop pin synchronizer with one trailing flop for rise/fall detection.
// No reset on purpose: the chain keeps tracking the pin through a reset, so a
// pin that is already high when reset releases never shows up as a false rise.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic i_pin,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the raw pin through the synchronizer and keep the previous level.
  always_ff @(posedge clk) begin
    r_sync <= {r_sync[STAGES-2:0], i_pin};
    r_prev <= r_sync[STAGES-1];
  end

  assign o_lvl  = r_sync[STAGES-1];
  assign o_rise =  r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_packet_rx.sv
// SPI slave receiver: oversamples cs/sck/sdi, assembles MSB-first frames,
// checks length and hands good frames out over valid/ready.
// Optional echo of the last accepted frame on sdo: define SPI_RX_ECHO_EN.
module spi_packet_rx
  import spi_pkg::*;
#(
  parameter int PKT_BITS    = PKT_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic                sck,
  input  logic                sdi,
  output logic                pkt_valid,
  output logic [PKT_BITS-1:0] pkt_data,
  input  logic                pkt_ready,
  output logic                frm_err,
  output logic                overrun
`ifdef SPI_RX_ECHO_EN
  ,
  output logic                sdo
`endif
);

  // Counter saturates one past a full frame so "exactly 24" and "more than 24" differ.
  localparam int             CW       = $clog2(PKT_BITS + 2);
  localparam logic [CW-1:0]  CNT_FULL = CW'(PKT_BITS);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(PKT_BITS + 1);

  logic w_cs_s, w_cs_rise, w_cs_fall;
  logic w_sck_s, w_sck_rise, w_sck_fall;
  logic w_sdi_s, w_sdi_rise, w_sdi_fall;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .i_pin(cs), .o_lvl(w_cs_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .i_pin(sck), .o_lvl(w_sck_s), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .i_pin(sdi), .o_lvl(w_sdi_s), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall));

  logic w_unused_sync;
  assign w_unused_sync = ^{w_sck_s, w_sdi_rise, w_sdi_fall};

  rx_state_t             r_state, w_state_nxt;
  logic [PKT_BITS-1:0]   r_sreg;
  logic [CW-1:0]         r_cnt;
  logic                  r_pkt_valid;
  logic [PKT_BITS-1:0]   r_pkt_data;
  logic                  r_frm_err, r_overrun;
  logic                  w_clr, w_shift, w_load, w_ovr, w_err;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-cycle actions; a shift and cs fall in the same cycle
  // both happen, so the last bit lands before CHECK looks at the count.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_ovr       = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_rise) begin
          w_clr       = 1'b1;
          w_state_nxt = RECV;
        end
      end
      RECV: begin
        w_shift = w_sck_rise;
        if (w_cs_fall) w_state_nxt = CHECK;
      end
      CHECK: begin
        if (r_cnt != CNT_FULL)              w_err  = 1'b1;
        else if (!r_pkt_valid || pkt_ready) w_load = 1'b1;
        else                                w_ovr  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (w_clr) begin
      r_cnt  <= '0;
    end else if (w_shift) begin
      r_sreg <= {r_sreg[PKT_BITS-2:0], w_sdi_s};
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
    end
  end

  // One-entry output buffer plus error/overrun pulses; a load in the same
  // cycle as a consume overrides the clear, giving back-to-back delivery.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pkt_valid <= 1'b0;
      r_pkt_data  <= '0;
      r_frm_err   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frm_err <= w_err;
      r_overrun <= w_ovr;
      if (r_pkt_valid && pkt_ready) r_pkt_valid <= 1'b0;
      if (w_load) begin
        r_pkt_valid <= 1'b1;
        r_pkt_data  <= r_sreg;
      end
    end
  end

  assign pkt_valid = r_pkt_valid;
  assign pkt_data  = r_pkt_data;
  assign frm_err   = r_frm_err;
  assign overrun   = r_overrun;

`ifdef SPI_RX_ECHO_EN
  logic [PKT_BITS-1:0] r_shadow, r_echo;
  logic                r_sdo;

  // Echo the last accepted frame: MSB on cs rise, next bit on each sck fall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shadow <= '0;
      r_echo   <= '0;
      r_sdo    <= 1'b0;
    end else begin
      if (w_load) r_shadow <= r_sreg;
      if (!w_cs_s) begin
        r_sdo <= 1'b0;
      end else if (w_cs_rise) begin
        r_echo <= r_shadow;
        r_sdo  <= r_shadow[PKT_BITS-1];
      end else if (w_sck_fall) begin
        r_echo <= {r_echo[PKT_BITS-2:0], 1'b0};
        r_sdo  <= r_echo[PKT_BITS-2];
      end
    end
  end

  assign sdo = r_sdo;
`else
  logic w_unused_echo;
  assign w_unused_echo = w_cs_s ^ w_sck_fall;
`endif

endmodule
